// File: rtl/sw_debounce.sv
// Per-bit switch debouncer: 2-flop synchronizer, shared sample-tick prescaler and a
// disagreement counter per bit. Define SW_EDGE_LATCH_EN to build the sticky rise-event latch.
module sw_debounce #(
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] sw_raw_i,
    input  logic [31:0] rise_clr_i,
    output logic [31:0] sw_o,
    output logic        sw_changed_o,
    output logic [31:0] sw_rise_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [31:0]   sync1_q;
    logic [31:0]   sync2_q;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick_s;
    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic [31:0]   sw_q;
    logic [31:0]   sw_d;
    logic          chg_q;
    logic          chg_d;

    // Two-stage synchronizer for the asynchronous board inputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 32'h0;
            sync2_q <= 32'h0;
        end else begin
            sync1_q <= sw_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Sample-tick prescaler, ticks on its last count value
    always_comb begin
        tick_s = (pre_q == DIV_LAST);
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // Per-bit acceptance: STABLE_CNT consecutive disagreeing ticks flip the output bit
    always_comb begin
        sw_d = sw_q;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!tick_s) begin
                cnt_d[i] = cnt_q[i];
            end else if (sync2_q[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        chg_d = (sw_d != sw_q);
    end

    // Prescaler, counters, debounced word and change pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
            sw_q  <= 32'h0;
            chg_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pre_q <= pre_d;
            sw_q  <= sw_d;
            chg_q <= chg_d;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_o         = sw_q;
    assign sw_changed_o = chg_q;

`ifdef SW_EDGE_LATCH_EN
    logic [31:0] rise_q;
    logic [31:0] rise_d;

    // Set has priority over clear when both hit the same bit
    always_comb begin
        rise_d = (rise_q & ~rise_clr_i) | (sw_d & ~sw_q);
    end

    // Sticky rise-event register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 32'h0;
        end else begin
            rise_q <= rise_d;
        end
    end

    assign sw_rise_o = rise_q;
`else
    logic rise_clr_unused_s;
    assign rise_clr_unused_s = ^rise_clr_i;
    assign sw_rise_o         = 32'h0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Randomized bench for sw_debounce against a sliding-window reference model of the tick samples.
module tb_sw_debounce;

    localparam int TD = 4;
    localparam int SC = 3;
`ifdef SW_EDGE_LATCH_EN
    localparam logic [31:0] EXP_RISE = 32'h1;
`else
    localparam logic [31:0] EXP_RISE = 32'h0;
`endif

    logic        clk_i      = 1'b0;
    logic        rst_ni     = 1'b0;
    logic [31:0] sw_raw_i   = 32'h0;
    logic [31:0] rise_clr_i = 32'h0;
    logic [31:0] sw_o;
    logic        sw_changed_o;
    logic [31:0] sw_rise_o;

    sw_debounce #(.TICK_DIV(TD), .STABLE_CNT(SC)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sw_raw_i     (sw_raw_i),
        .rise_clr_i   (rise_clr_i),
        .sw_o         (sw_o),
        .sw_changed_o (sw_changed_o),
        .sw_rise_o    (sw_rise_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int chg_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw history gives the synchronized value, and the last SC tick
    // samples decide a flip when every one of them disagrees with the current output.
    logic [31:0] m_raw_q[$];
    logic [31:0] m_win[$];
    logic [31:0] m_out  = 32'h0;
    logic        m_chg  = 1'b0;
    logic [31:0] m_rise = 32'h0;
    int          m_n    = 0;
    logic [31:0] m_s;
    logic [31:0] m_nx;

    function automatic logic [31:0] m_sync();
        return (m_raw_q.size() >= 2) ? m_raw_q[m_raw_q.size() - 2] : 32'h0;
    endfunction

    function automatic bit m_is_tick();
        return (m_n % TD) == (TD - 1);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] s);
        logic [31:0] w[$];
        logic [31:0] res;
        bit          all_d;
        w = m_win;
        w.push_back(s);
        if (w.size() > SC) void'(w.pop_front());
        res = m_out;
        if (w.size() == SC) begin
            for (int b = 0; b < 32; b++) begin
                all_d = 1'b1;
                foreach (w[j]) if (w[j][b] == m_out[b]) all_d = 1'b0;
                if (all_d) res[b] = ~m_out[b];
            end
        end
        return res;
    endfunction

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_raw_q.delete();
            m_win.delete();
            m_out  = 32'h0;
            m_chg  = 1'b0;
            m_rise = 32'h0;
            m_n    = 0;
        end else begin
            m_s  = m_sync();
            m_nx = m_out;
            if (m_is_tick()) begin
                m_nx = m_next(m_s);
                m_win.push_back(m_s);
                if (m_win.size() > SC) void'(m_win.pop_front());
            end
            m_chg  = (m_nx != m_out);
            m_rise = EXP_RISE[0] ? ((m_rise & ~rise_clr_i) | (m_nx & ~m_out)) : 32'h0;
            m_out  = m_nx;
            m_raw_q.push_back(sw_raw_i);
            if (m_raw_q.size() > 2) void'(m_raw_q.pop_front());
            m_n++;
        end
    end

    always @(negedge clk_i) begin
        chk("sw_o", sw_o, m_out);
        chk("changed", 32'(sw_changed_o), 32'(m_chg));
        chk("rise", sw_rise_o, m_rise);
        if (sw_changed_o) chg_total++;
    end

    task automatic wait_sw(input logic [31:0] mask, input logic [31:0] val, output int lat);
        lat = 0;
        while (((sw_o & mask) !== val) && lat < 80) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        bit found;
        logic [31:0] nx;

        #1;
        chk("rst_sw", sw_o, 32'h0);
        chk("rst_chg", 32'(sw_changed_o), 32'h0);
        chk("rst_rise", sw_rise_o, 32'h0);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);

        // Clean single-bit edge
        base = chg_total;
        sw_raw_i = 32'h1;
        wait_sw(32'h1, 32'h1, lat);
        chk("clean_lat_ok", 32'(lat >= 9 && lat <= 15), 32'h1);
        repeat (20) @(negedge clk_i);
        chk("clean_pulses", 32'(chg_total - base), 32'h1);
        sw_raw_i = 32'h0;
        repeat (25) @(negedge clk_i);

        // Bounce on bit 0 must never be accepted
        base = chg_total;
        for (int k = 0; k < 12; k++) begin
            sw_raw_i[0] = ~sw_raw_i[0];
            repeat (5) @(negedge clk_i);
        end
        sw_raw_i = 32'h0;
        repeat (20) @(negedge clk_i);
        chk("bounce_sw", sw_o, 32'h0);
        chk("bounce_pulses", 32'(chg_total - base), 32'h0);

        // Multi-bit simultaneous update
        base = chg_total;
        sw_raw_i = 32'hA5A5_F00F;
        wait_sw(32'hFFFF_FFFF, 32'hA5A5_F00F, lat);
        chk("multi_first", sw_o, 32'hA5A5_F00F);
        repeat (20) @(negedge clk_i);
        chk("multi_pulses", 32'(chg_total - base), 32'h1);
        sw_raw_i = 32'h0;
        repeat (25) @(negedge clk_i);

        // Reset in the middle of a bit-3 debounce
        sw_raw_i = 32'h8;
        repeat (10) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_sw", sw_o, 32'h0);
        chk("midrst_chg", 32'(sw_changed_o), 32'h0);
        chk("midrst_rise", sw_rise_o, 32'h0);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        base = chg_total;
        wait_sw(32'h8, 32'h8, lat);
        chk("midrst_lat", 32'(lat), 32'd12);
        repeat (5) @(negedge clk_i);
        chk("midrst_pulses", 32'(chg_total - base), 32'h1);
        sw_raw_i = 32'h0;
        repeat (25) @(negedge clk_i);

        // Rise latch: set beats a simultaneous clear, then a lone clear empties it
        rise_clr_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        rise_clr_i = 32'h0;
        sw_raw_i = 32'h20;
        wait_sw(32'h20, 32'h20, lat);
        chk("rise5_first", 32'(sw_rise_o[5]), EXP_RISE);
        sw_raw_i = 32'h0;
        wait_sw(32'h20, 32'h0, lat);
        sw_raw_i = 32'h20;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk_i);
            nx = m_is_tick() ? m_next(m_sync()) : m_out;
            if (nx[5] && !m_out[5]) begin
                rise_clr_i = 32'h20;
                found = 1'b1;
            end
        end
        chk("rise5_pred", 32'(found), 32'h1);
        @(negedge clk_i);
        rise_clr_i = 32'h0;
        chk("rise5_sw", 32'(sw_o[5]), 32'h1);
        chk("rise5_setwins", 32'(sw_rise_o[5]), EXP_RISE);
        repeat (5) @(negedge clk_i);
        rise_clr_i = 32'h20;
        @(negedge clk_i);
        rise_clr_i = 32'h0;
        chk("rise5_clr", 32'(sw_rise_o[5]), 32'h0);

        // Random levels, single-bit flips and holds with sporadic clears
        for (int it = 0; it < 60; it++) begin
            case ($urandom % 3)
                0: sw_raw_i = $urandom;
                1: sw_raw_i = sw_raw_i ^ (32'h1 << ($urandom % 32));
                default: sw_raw_i = sw_raw_i;
            endcase
            rise_clr_i = (($urandom % 4) == 0) ? $urandom : 32'h0;
            @(negedge clk_i);
            rise_clr_i = 32'h0;
            repeat ($urandom_range(1, 30)) @(negedge clk_i);
        end
        repeat (30) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set the sample-tick period in clk_i cycles (legal range >= 1).
REQ-002 Parameter STABLE_CNT, default 4, SHALL set the number of consecutive disagreeing ticks needed to accept a new level (legal range >= 1).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 sw_raw_i  input  32  SHALL carry the raw, asynchronous, bouncing board switch levels.
REQ-006 rise_clr_i  input  32  SHALL be a per-bit clear mask for the rise-latch register.
REQ-007 sw_o  output  32  SHALL be the debounced switch word, connected to the CPU switch-input port io_sw_i.
REQ-008 sw_changed_o  output  1  SHALL be a one-cycle pulse marking any update of sw_o.
REQ-009 sw_rise_o  output  32  SHALL be the sticky per-bit 0->1 event register.

Function
REQ-010 Each sw_raw_i bit SHALL pass through a 2-flop synchronizer; the second-stage value is "sync[i]".
REQ-011 A prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick in the cycle in which count == TICK_DIV-1; TICK_DIV=1 SHALL tick every cycle.
REQ-012 Each bit SHALL have a disagreement counter; in non-tick cycles, counters and sw_o SHALL hold.
REQ-013 On a tick with sync[i] == sw_o[i], counter[i] SHALL clear to 0.
REQ-014 On a tick with sync[i] != sw_o[i] and counter[i] < STABLE_CNT-1, counter[i] SHALL increment by 1.
REQ-015 On a tick with sync[i] != sw_o[i] and counter[i] == STABLE_CNT-1, sw_o[i] SHALL take sync[i] and counter[i] SHALL clear to 0.
REQ-016 A new level SHALL therefore be accepted only after exactly STABLE_CNT consecutive ticks of disagreement; any agreeing tick SHALL restart the count.
REQ-017 The counter width SHALL be sized so that STABLE_CNT-1 is representable; counters SHALL never wrap.
REQ-018 sw_changed_o SHALL be high for exactly the one cycle in which sw_o first shows an updated value, including when several bits update on the same tick (single pulse).
REQ-019 Latency from a stable sw_raw_i change to sw_o SHALL be at most 2 + STABLE_CNT*TICK_DIV + 1 cycles and at least 2 + (STABLE_CNT-1)*TICK_DIV + 1 cycles.
REQ-020 sw_o SHALL be registered; it SHALL have no combinational path from sw_raw_i.

Reset
REQ-021 While rst_ni is low, synchronizers, prescaler, counters, sw_o, sw_changed_o and sw_rise_o SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-debounce SHALL discard partial counts; after release, a switch held at 1 SHALL reappear on sw_o only after a full debounce interval, with a sw_changed_o pulse.
REQ-023 The first tick after reset release SHALL occur TICK_DIV cycles after the first active clock edge.

Configuration
REQ-024 Macro SW_EDGE_LATCH_EN SHALL control the rise latch.
REQ-025 With SW_EDGE_LATCH_EN defined, sw_rise_o[i] SHALL set in the cycle sw_o[i] goes 0->1 and SHALL clear on the clock edge where rise_clr_i[i]=1.
REQ-026 With SW_EDGE_LATCH_EN defined, simultaneous set and clear on the same bit SHALL leave sw_rise_o[i]=1 (set wins).
REQ-027 Without SW_EDGE_LATCH_EN, sw_rise_o SHALL be constant 0, rise_clr_i SHALL be ignored, and no latch flops SHALL be synthesized.

Verification (TICK_DIV=4, STABLE_CNT=3)
REQ-028 Clean edge: sw_raw_i 0 -> 0x0000_0001, held -> sw_o = 0x0000_0001 within 9..15 cycles of the edge, with exactly one sw_changed_o pulse.
REQ-029 Bounce: sw_raw_i[0] toggles every 5 cycles for 60 cycles, then returns to 0 -> sw_o stays 0 and sw_changed_o never asserts.
REQ-030 Multi-bit: sw_raw_i 0 -> 0xA5A5_F00F in one cycle -> sw_o = 0xA5A5_F00F on a single cycle, with a single sw_changed_o pulse.
REQ-031 Reset mid-operation: rst_ni is pulled low 2 ticks into a debounce of bit 3 while sw_raw_i[3]=1 is held -> all outputs are 0 immediately; after release, sw_o[3]=1 appears only after 3 further full ticks.
REQ-032 Latch (SW_EDGE_LATCH_EN defined): bit 5 rises, and rise_clr_i[5] is pulsed in the same cycle as a second rise on bit 5 -> sw_rise_o[5] stays 1; a later lone clear -> 0. With the macro undefined -> sw_rise_o = 0 throughout.
